// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: result sources, access widths,
// FSM encoding and the MEM/WB record.
package mem_access_stage_pkg;

    localparam int unsigned XLEN_P       = 32;
    localparam int unsigned REG_ADDR_W_P = 5;

    typedef enum logic [1:0] {
        RESULT_SRC__ALU = 2'b00,
        RESULT_SRC__MEM = 2'b01,
        RESULT_SRC__PC4 = 2'b10
    } result_src_t;

    localparam logic [2:0] MEM_W__B  = 3'b000;
    localparam logic [2:0] MEM_W__H  = 3'b001;
    localparam logic [2:0] MEM_W__W  = 3'b010;
    localparam logic [2:0] MEM_W__BU = 3'b100;
    localparam logic [2:0] MEM_W__HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } mem_fsm_t;

    typedef struct packed {
        logic                    valid;
        logic                    reg_write;
        logic [1:0]              result_src;
        logic [REG_ADDR_W_P-1:0] rd;
        logic [XLEN_P-1:0]       alu_result;
        logic [XLEN_P-1:0]       read_data;
        logic [XLEN_P-1:0]       pc_cur;
        logic                    misaligned;
    } mem_to_wb_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational byte-lane logic: store strobes/replication, load extraction
// with sign/zero extension, and access-fault detection.
module mem_access_stage_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr,
    input  logic [XLEN_P-1:0] store_data,
    input  logic [XLEN_P-1:0] rdata,
    output logic [3:0]        wstrb,
    output logic [XLEN_P-1:0] wdata,
    output logic [XLEN_P-1:0] load_ext,
    output logic              fault
);

    logic [XLEN_P-1:0] shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    always_comb begin
        shifted  = rdata >> {addr, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb    = '0;
        wdata    = store_data;
        load_ext = '0;
        fault    = 1'b0;
        case (funct3)
            MEM_W__B, MEM_W__BU: begin
                wstrb    = 4'b0001 << addr;
                wdata    = {4{store_data[7:0]}};
                load_ext = (funct3 == MEM_W__B) ? {{24{byte_sel[7]}}, byte_sel}
                                                : {24'h0, byte_sel};
            end
            MEM_W__H, MEM_W__HU: begin
                fault    = addr[0];
                wstrb    = 4'b0011 << {addr[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                load_ext = (funct3 == MEM_W__H) ? {{16{half_sel[15]}}, half_sel}
                                                : {16'h0, half_sel};
            end
            MEM_W__W: begin
                fault    = (addr != 2'b00);
                wstrb    = 4'b1111;
                load_ext = rdata;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues valid/ready data-memory requests, stalls upstream
// while an access is outstanding, and registers the MEM/WB record.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [1:0]            ex_result_src,
    input  logic                  ex_mem_write,
    input  logic                  ex_reg_write,
    input  logic [2:0]            ex_funct3,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [XLEN-1:0]       ex_pc_cur,
    output logic                  stall,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic                  dmem_rsp_valid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_result_src,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_alu_result,
    output logic [XLEN-1:0]       wb_read_data,
    output logic [XLEN-1:0]       wb_pc_cur,
    output logic                  misaligned
);

    mem_fsm_t   state, state_next;
    mem_to_wb_t wb_q, wb_next, cap_q;
    logic              req_q, cap_we;
    logic [2:0]        cap_funct3;
    logic [XLEN-1:0]   cap_addr, cap_wdata;
    logic [3:0]        cap_wstrb;
    logic              mem_op, start, complete;
    logic [2:0]        al_funct3;
    logic [1:0]        al_addr;
    logic [3:0]        al_wstrb;
    logic [XLEN-1:0]   al_wdata, al_load;
    logic              al_fault;

    assign mem_op = ex_valid && (ex_mem_write || ex_result_src == RESULT_SRC__MEM);
    assign start  = (state == IDLE) && mem_op && !al_fault;

    // The aligner is shared: it classifies the incoming op in IDLE and
    // extracts load data from the captured op otherwise.
    assign al_funct3 = (state == IDLE) ? ex_funct3 : cap_funct3;
    assign al_addr   = (state == IDLE) ? ex_alu_result[1:0] : cap_addr[1:0];

    mem_access_stage_align u_align (
        .funct3     (al_funct3),
        .addr       (al_addr),
        .store_data (ex_store_data),
        .rdata      (dmem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_ext   (al_load),
        .fault      (al_fault)
    );

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                    stall      = 1'b1;
                end
            end
            REQ: begin
                stall = !(cap_we && dmem_req_ready);
                if (dmem_req_ready) begin
                    state_next = cap_we ? IDLE : RESP;
                    complete   = cap_we;
                end
            end
            RESP: begin
                stall = !dmem_rsp_valid;
                if (dmem_rsp_valid) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wb_next = '0;
        if (state == IDLE && !start) begin
            wb_next.valid      = ex_valid;
            wb_next.reg_write  = ex_reg_write && !(mem_op && al_fault);
            wb_next.result_src = ex_result_src;
            wb_next.rd         = ex_rd;
            wb_next.alu_result = ex_alu_result;
            wb_next.pc_cur     = ex_pc_cur;
            wb_next.misaligned = mem_op && al_fault;
        end else if (complete) begin
            wb_next           = cap_q;
            wb_next.valid     = 1'b1;
            wb_next.read_data = cap_we ? '0 : al_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            wb_q       <= '0;
            cap_q      <= '0;
            cap_we     <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
        end else begin
            state <= state_next;
            req_q <= (state_next == REQ);
            wb_q  <= wb_next;
            if (start) begin
                cap_q            <= '0;
                cap_q.reg_write  <= ex_reg_write;
                cap_q.result_src <= ex_result_src;
                cap_q.rd         <= ex_rd;
                cap_q.alu_result <= ex_alu_result;
                cap_q.pc_cur     <= ex_pc_cur;
                cap_we           <= ex_mem_write;
                cap_funct3       <= ex_funct3;
                cap_addr         <= ex_alu_result;
                cap_wdata        <= al_wdata;
                cap_wstrb        <= ex_mem_write ? al_wstrb : 4'b0000;
            end
        end
    end

    assign dmem_req_valid = req_q;
    assign dmem_we        = cap_we;
    assign dmem_addr      = {cap_addr[XLEN-1:2], 2'b00};
    assign dmem_wdata     = cap_wdata;
    assign dmem_wstrb     = cap_wstrb;

    assign wb_valid      = wb_q.valid;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_result_src = wb_q.result_src;
    assign wb_rd         = wb_q.rd;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_read_data  = wb_q.read_data;
    assign wb_pc_cur     = wb_q.pc_cur;
    assign misaligned    = wb_q.misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, stores, loads with
// wait states, access faults, backpressure and reset during a response.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [1:0]  ex_result_src;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc_cur;
    logic        stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [1:0]  wb_result_src;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic [31:0] wb_pc_cur;
    logic        misaligned;

    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned total    = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_result_src  (ex_result_src),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_funct3      (ex_funct3),
        .ex_rd          (ex_rd),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_pc_cur      (ex_pc_cur),
        .stall          (stall),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_result_src  (wb_result_src),
        .wb_rd          (wb_rd),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data),
        .wb_pc_cur      (wb_pc_cur),
        .misaligned     (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        ex_valid       = 1'b0;
        ex_result_src  = 2'b00;
        ex_mem_write   = 1'b0;
        ex_reg_write   = 1'b0;
        ex_funct3      = 3'b000;
        ex_rd          = 5'd0;
        ex_alu_result  = 32'h0;
        ex_store_data  = 32'h0;
        ex_pc_cur      = 32'h0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
    endtask

    task automatic set_op(input logic [1:0] src, input logic we, input logic rw,
                          input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [31:0] pc);
        ex_valid      = 1'b1;
        ex_result_src = src;
        ex_mem_write  = we;
        ex_reg_write  = rw;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_alu_result = alu;
        ex_store_data = sdata;
        ex_pc_cur     = pc;
    endtask

    // Zero-wait request acceptance, then `waits` response wait cycles.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input int unsigned waits,
                            input logic [4:0] rd);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        set_op(2'b01, 1'b0, 1'b1, f3, rd, addr, 32'h0, 32'h1000);
        dmem_req_ready = 1'b1;
        #1 chk("ld_stall_idle", stall, 1);
        tick();
        chk("ld_req_valid", dmem_req_valid, 1);
        chk("ld_addr", dmem_addr, word_addr);
        chk("ld_wstrb", dmem_wstrb, 0);
        chk("ld_stall_req", stall, 1);
        tick();
        dmem_req_ready = 1'b0;
        chk("ld_req_dropped", dmem_req_valid, 0);
        for (int unsigned i = 0; i < waits; i++) begin
            chk("ld_stall_wait", stall, 1);
            tick();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        #1 chk("ld_stall_rsp", stall, 0);
        tick();
        ex_valid       = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'h0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wb_alu", wb_alu_result, 0);
        reset = 1'b1;
        tick();

        // Non-memory op
        set_op(2'b00, 1'b0, 1'b1, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h40);
        #1 chk("alu_stall", stall, 0);
        tick();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_result", wb_alu_result, 32'h1234);
        chk("alu_wb_rd", wb_rd, 5);
        chk("alu_wb_rw", wb_reg_write, 1);
        chk("alu_wb_rdata", wb_read_data, 0);
        chk("alu_wb_pc", wb_pc_cur, 32'h40);
        chk("alu_stall_after", stall, 0);
        ex_valid = 1'b0;
        tick();
        chk("bubble_wb_valid", wb_valid, 0);

        // SB at 0x102
        set_op(2'b00, 1'b1, 1'b0, 3'b000, 5'd0, 32'h102, 32'h0000_00AB, 32'h44);
        dmem_req_ready = 1'b1;
        #1 chk("sb_stall_idle", stall, 1);
        chk("sb_no_req_idle", dmem_req_valid, 0);
        tick();
        chk("sb_req_valid", dmem_req_valid, 1);
        chk("sb_we", dmem_we, 1);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_wstrb", dmem_wstrb, 4'b0100);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        chk("sb_stall_req", stall, 0);
        chk("sb_wb_bubble", wb_valid, 0);
        ex_valid = 1'b0;
        tick();
        dmem_req_ready = 1'b0;
        chk("sb_wb_valid", wb_valid, 1);
        chk("sb_wb_rw", wb_reg_write, 0);
        chk("sb_wb_pc", wb_pc_cur, 32'h44);
        chk("sb_req_done", dmem_req_valid, 0);

        // SH at 0x502
        set_op(2'b00, 1'b1, 1'b0, 3'b001, 5'd0, 32'h502, 32'h0000_1234, 32'h48);
        dmem_req_ready = 1'b1;
        tick();
        chk("sh_wstrb", dmem_wstrb, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'h1234_1234);
        ex_valid = 1'b0;
        tick();
        dmem_req_ready = 1'b0;
        chk("sh_wb_valid", wb_valid, 1);

        // Loads
        run_load(3'b000, 32'h203, 32'h8000_0000, 3, 5'd7);
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_rdata", wb_read_data, 32'hFFFF_FF80);
        chk("lb_rd", wb_rd, 7);
        chk("lb_rw", wb_reg_write, 1);
        chk("lb_src", wb_result_src, 2'b01);
        chk("lb_alu", wb_alu_result, 32'h203);
        run_load(3'b100, 32'h203, 32'h8000_0000, 1, 5'd8);
        chk("lbu_rdata", wb_read_data, 32'h0000_0080);
        run_load(3'b001, 32'h202, 32'h8001_0000, 0, 5'd9);
        chk("lh_rdata", wb_read_data, 32'hFFFF_8001);
        run_load(3'b101, 32'h202, 32'h8001_0000, 0, 5'd9);
        chk("lhu_rdata", wb_read_data, 32'h0000_8001);
        tick();
        chk("ld_bubble", wb_valid, 0);

        // Misaligned LW and illegal funct3
        set_op(2'b01, 1'b0, 1'b1, 3'b010, 5'd3, 32'h302, 32'h0, 32'h50);
        #1 chk("lw_mis_stall", stall, 0);
        chk("lw_mis_noreq", dmem_req_valid, 0);
        tick();
        chk("lw_mis_flag", misaligned, 1);
        chk("lw_mis_wb_valid", wb_valid, 1);
        chk("lw_mis_rw", wb_reg_write, 0);
        chk("lw_mis_noreq2", dmem_req_valid, 0);
        set_op(2'b01, 1'b0, 1'b1, 3'b011, 5'd3, 32'h300, 32'h0, 32'h54);
        tick();
        chk("f3_011_flag", misaligned, 1);
        chk("f3_011_rw", wb_reg_write, 0);
        chk("f3_011_noreq", dmem_req_valid, 0);
        ex_valid = 1'b0;
        tick();
        chk("mis_one_cycle", misaligned, 0);

        // SW with 4 cycles of backpressure
        set_op(2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h500, 32'hDEAD_BEEF, 32'h58);
        tick();
        ex_store_data = 32'h5555_5555;
        for (int unsigned i = 0; i < 4; i++) begin
            chk("bp_req_valid", dmem_req_valid, 1);
            chk("bp_addr", dmem_addr, 32'h500);
            chk("bp_wdata", dmem_wdata, 32'hDEAD_BEEF);
            chk("bp_wstrb", dmem_wstrb, 4'b1111);
            chk("bp_stall", stall, 1);
            tick();
        end
        dmem_req_ready = 1'b1;
        #1 chk("bp_stall_accept", stall, 0);
        tick();
        ex_valid       = 1'b0;
        dmem_req_ready = 1'b0;
        chk("bp_wb_valid", wb_valid, 1);
        chk("bp_req_done", dmem_req_valid, 0);
        tick();
        chk("bp_single_accept", dmem_req_valid, 0);
        chk("bp_wb_once", wb_valid, 0);

        // Reset while waiting in RESP
        set_op(2'b01, 1'b0, 1'b1, 3'b010, 5'd4, 32'h600, 32'h0, 32'h60);
        dmem_req_ready = 1'b1;
        tick();
        tick();
        dmem_req_ready = 1'b0;
        chk("rr_in_resp_stall", stall, 1);
        ex_valid = 1'b0;
        reset    = 1'b0;
        tick();
        reset = 1'b1;
        chk("rr_wb_valid", wb_valid, 0);
        chk("rr_req_valid", dmem_req_valid, 0);
        chk("rr_stall", stall, 0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h1234_5678;
        #1 chk("rr_rsp_stall", stall, 0);
        tick();
        dmem_rsp_valid = 1'b0;
        chk("rr_rsp_ignored", wb_valid, 0);
        chk("rr_rsp_rdata", wb_read_data, 0);
        run_load(3'b010, 32'h400, 32'hCAFE_F00D, 1, 5'd6);
        chk("rr_lw_valid", wb_valid, 1);
        chk("rr_lw_rdata", wb_read_data, 32'hCAFE_F00D);
        chk("rr_lw_rd", wb_rd, 6);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
